// File: rtl/serial_subtractor_with_borrow.sv
// serial_subtractor_with_borrow: bit-serial A-B-Bin, LSB first, start/busy/done handshake; SERIAL_SUB_OVERFLOW_EN adds o_overflow
module serial_subtractor_with_borrow #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] aReg, bReg, resReg;
  logic borrowFlop, diffBit, borrowNext, accept, lastShift;
  logic [CW-1:0] cnt;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovfReg;
`endif
  always_comb begin
    diffBit    = aReg[0] ^ bReg[0] ^ borrowFlop;
    borrowNext = (~aReg[0] & bReg[0]) | (~(aReg[0] ^ bReg[0]) & borrowFlop);
    accept     = i_start && (state == IDLE || state == DONE);
    lastShift  = cnt == CW'(WIDTH - 1);
  end
  assign o_busy = state == SHIFT;
  // Results are published on the edge leaving DONE, so a new op can be accepted on that same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      aReg       <= '0;
      bReg       <= '0;
      resReg     <= '0;
      borrowFlop <= 1'b0;
      cnt        <= '0;
      o_done     <= 1'b0;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovfReg     <= 1'b0;
      o_overflow <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      if (state == DONE) begin
        o_diff   <= resReg;
        o_borrow <= borrowFlop;
        o_done   <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
        o_overflow <= ovfReg;
`endif
      end
      if (accept) begin
        aReg       <= i_minuend;
        bReg       <= i_subtrahend;
        borrowFlop <= i_borrow;
        cnt        <= '0;
        state      <= SHIFT;
      end else if (state == SHIFT) begin
        resReg     <= {diffBit, resReg[WIDTH-1:1]};
        aReg       <= aReg >> 1;
        bReg       <= bReg >> 1;
        borrowFlop <= borrowNext;
        cnt        <= cnt + 1'b1;
        state      <= lastShift ? DONE : SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
        if (lastShift) ovfReg <= borrowFlop ^ borrowNext;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor_with_borrow.sv
// tb_serial_subtractor_with_borrow: directed and random checks against an arithmetic reference model
module tb_serial_subtractor_with_borrow;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, borrowIn = 1'b0;
  logic [3:0] minuend = '0, subtrahend = '0, diff;
  logic busy, done, borrowOut;
  logic [3:0] prevDiff = '0;
  int checks = 0, failures = 0;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic overflow;
`endif
  serial_subtractor_with_borrow #(.WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_minuend(minuend),
    .i_subtrahend(subtrahend), .i_borrow(borrowIn), .o_busy(busy),
    .o_done(done), .o_diff(diff), .o_borrow(borrowOut)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .o_overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] refSub(input logic [3:0] a, input logic [3:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {4'b0, bin};
  endfunction
  function automatic logic refOvf(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return r < -8 || r > 7;
  endfunction
  task automatic scramble();
    minuend    = 4'($urandom_range(0, 15));
    subtrahend = 4'($urandom_range(0, 15));
    borrowIn   = 1'($urandom_range(0, 1));
  endtask
  task automatic startOp(input logic [3:0] a, input logic [3:0] b, input logic bin);
    minuend = a;
    subtrahend = b;
    borrowIn = bin;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
  endtask
  task automatic waitDone(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] e;
    int lat, busyCnt;
    bit seen;
    e = refSub(a, b, bin);
    lat = 0;
    busyCnt = int'(busy);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if (done) seen = 1;
      else begin
        busyCnt += int'(busy);
        chk("diff_hold", 32'(diff), 32'(prevDiff));
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", lat, 5);
    chk("busy_cycles", busyCnt, 4);
    chk("diff", 32'(diff), 32'(e[3:0]));
    chk("borrow", 32'(borrowOut), 32'(e[4]));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("overflow", 32'(overflow), 32'(refOvf(a, b, bin)));
`endif
    prevDiff = e[3:0];
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("diff_after_done", 32'(diff), 32'(prevDiff));
  endtask
  task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic bin);
    startOp(a, b, bin);
    waitDone(a, b, bin);
  endtask
  initial begin
    logic [3:0] a, b;
    logic bin;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrowOut), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_overflow", 32'(overflow), 0);
`endif
    runOp(4'd5, 4'd3, 1'b0);
    runOp(4'd3, 4'd5, 1'b0);
    runOp(4'd0, 4'd0, 1'b1);
    runOp(4'd8, 4'd1, 1'b0);
    startOp(4'd6, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      scramble();
      start = (i != 1);
      tick();
      chk("busy_mid_shift", 32'(busy), 1);
    end
    start = 1'b0;
    tick();
    chk("done_state_busy", 32'(busy), 0);
    chk("done_state_done", 32'(done), 0);
    minuend = 4'd10;
    subtrahend = 4'd13;
    borrowIn = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    chk("b2b_done", 32'(done), 1);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_first_diff", 32'(diff), 4);
    chk("b2b_first_borrow", 32'(borrowOut), 0);
    prevDiff = 4'd4;
    waitDone(4'd10, 4'd13, 1'b1);
    startOp(4'd12, 4'd7, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(diff), 0);
    chk("abort_borrow", 32'(borrowOut), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 0);
    end
    prevDiff = 4'd0;
    runOp(4'd9, 4'd4, 1'b0);
    for (int n = 0; n < 500; n++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      bin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 4'd0; b = 4'hF; end
        default: ;
      endcase
      runOp(a, b, bin);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
